// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding, SCK divider derivation
// and the CPHA-dependent role (sample / shift) of each SCK edge.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_t;

    // System clocks per SCK period; system clock in MHz, SCK in kHz.
    function automatic int unsigned calc_clk_div(input int unsigned clk_mhz,
                                                 input int unsigned sck_khz);
        return (clk_mhz * 32'd1000) / sck_khz;
    endfunction

    // CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge.
    function automatic logic is_sample_edge(input logic cpha, input logic first_edge);
        return first_edge ^ cpha;
    endfunction

    // The very first leading edge (CPHA=1) and the final trailing edge (CPHA=0)
    // must not advance MOSI.
    function automatic logic is_shift_edge(input logic cpha,
                                           input logic first_edge,
                                           input logic frame_first,
                                           input logic frame_last);
        return cpha ? (first_edge & ~frame_first) : (~first_edge & ~frame_last);
    endfunction

endpackage

// File: rtl/spi_clock.sv
// SCK generator: toggles every CLK_DIV/2 cycles while enabled and flags which
// edge (leading / trailing relative to CPOL) happens at the coming clock edge.
module spi_clock #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CPOL    = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_sck,
    output logic o_first_edge_c,
    output logic o_second_edge_c
);

    localparam int unsigned HALF  = CLK_DIV / 2;
    localparam int unsigned DIV_W = $clog2(HALF);
    localparam logic        IDLE_LVL = 1'(CPOL);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_sck;
    logic             w_tick;

    assign w_tick = i_en && (r_div_cnt == DIV_W'(HALF - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_div_cnt <= '0;
            r_sck     <= IDLE_LVL;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_sck     <= ~r_sck;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    assign o_sck           = r_sck;
    assign o_first_edge_c  = w_tick && (r_sck == IDLE_LVL);
    assign o_second_edge_c = w_tick && (r_sck != IDLE_LVL);

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-frame SPI master: CS setup, DATA_WIDTH-bit full-duplex shift in any
// CPOL/CPHA mode, CS hold, then a one-cycle RxValid_O strobe.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50,
    parameter int unsigned SPI_CLK_FREQ = 1000,
    parameter int unsigned CPOL         = 0,
    parameter int unsigned CPHA         = 0,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned CS_SETUP     = 2,
    parameter int unsigned CS_HOLD      = 2
) (
    input  logic                  Clk_I,
    input  logic                  RstN_I,
    input  logic                  TxValid_I,
    input  logic [DATA_WIDTH-1:0] TxData_I,
    output logic                  TxReady_O,
    output logic [DATA_WIDTH-1:0] RxData_O,
    output logic                  RxValid_O,
    output logic                  Busy_O,
    output logic                  SCK_O,
    output logic                  MOSI_O,
    input  logic                  MISO_I,
    output logic                  CS_N_O
);

    localparam int unsigned CLK_DIV = calc_clk_div(CLK_FREQ, SPI_CLK_FREQ);
    localparam int unsigned EDGE_W  = $clog2(2 * DATA_WIDTH);
    localparam int unsigned CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH - 1);

    spi_state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic                  r_sck_en, w_sck_en_nxt;
    logic                  w_load, w_done;
    logic                  w_rst;
    logic                  w_first_edge, w_second_edge, w_edge;
    logic                  w_sample, w_shift;
    logic [EDGE_W-1:0]     r_edge_cnt;
    logic [DATA_WIDTH-2:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx, r_rx_data;
    logic                  r_mosi, r_cs_n, r_rx_valid, r_tx_ready, r_busy;

    assign w_rst = ~RstN_I;

    spi_clock #(
        .CLK_DIV (CLK_DIV),
        .CPOL    (CPOL)
    ) u_spi_clock (
        .i_clk           (Clk_I),
        .i_rst           (w_rst),
        .i_en            (r_sck_en),
        .o_sck           (SCK_O),
        .o_first_edge_c  (w_first_edge),
        .o_second_edge_c (w_second_edge)
    );

    assign w_edge   = w_first_edge | w_second_edge;
    assign w_sample = w_edge && is_sample_edge(1'(CPHA), w_first_edge);
    assign w_shift  = w_edge && is_shift_edge(1'(CPHA), w_first_edge,
                                              r_edge_cnt == '0, r_edge_cnt == LAST_EDGE);

    always_ff @(posedge Clk_I) begin
        if (!RstN_I) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_sck_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sck_en <= w_sck_en_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sck_en_nxt = r_sck_en;
        w_load       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (TxValid_I) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
                    w_cnt_nxt    = '0;
                    w_sck_en_nxt = 1'b1;
                    w_state_nxt  = ST_SHIFT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (w_edge && (r_edge_cnt == LAST_EDGE)) begin
                    w_sck_en_nxt = 1'b0;
                    w_state_nxt  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_cnt == CNT_W'(CS_HOLD - 1)) begin
                    w_cnt_nxt   = '0;
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_sck_en_nxt = 1'b0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    // Datapath: MOSI holds the current bit, r_tx the bits still to be sent.
    always_ff @(posedge Clk_I) begin
        if (!RstN_I) begin
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_rx_valid <= 1'b0;
            r_edge_cnt <= '0;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_ready <= (w_state_nxt == ST_IDLE);
            r_busy     <= (w_state_nxt != ST_IDLE);
            if (w_load) begin
                r_tx       <= TxData_I[DATA_WIDTH-2:0];
                r_mosi     <= TxData_I[DATA_WIDTH-1];
                r_cs_n     <= 1'b0;
                r_edge_cnt <= '0;
            end
            if (w_edge) begin
                r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
            end
            if (w_shift) begin
                r_mosi <= r_tx[DATA_WIDTH-2];
                r_tx   <= r_tx << 1;
            end
            if (w_sample) begin
                r_rx <= {r_rx[DATA_WIDTH-2:0], MISO_I};
            end
            if (w_done) begin
                r_cs_n     <= 1'b1;
                r_mosi     <= 1'b0;
                r_rx_data  <= r_rx;
                r_rx_valid <= 1'b1;
            end
        end
    end

    assign TxReady_O = r_tx_ready;
    assign Busy_O    = r_busy;
    assign MOSI_O    = r_mosi;
    assign CS_N_O    = r_cs_n;
    assign RxData_O  = r_rx_data;
    assign RxValid_O = r_rx_valid;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: one instance per CPOL/CPHA mode, each with a
// behavioural SPI slave; instance 0 can also be looped back (MISO = MOSI).
module tb_spi_master_ctrl;

    localparam int EXP_LAT   = 1 + 2 + 16 * 10 + 2;
    localparam int EXP_RISES = 16;

    logic        clk;
    logic        rst_n;
    logic        tx_valid   [4];
    logic [15:0] tx_data    [4];
    logic        tx_ready   [4];
    logic [15:0] rx_data    [4];
    logic        rx_valid   [4];
    logic        busy       [4];
    logic        sck        [4];
    logic        mosi       [4];
    logic        cs_n       [4];
    logic        lb         [4];
    logic [15:0] slave_word [4];
    logic [15:0] sl_rx      [4];

    int n_tests;
    int n_fail;

    typedef struct {
        int          mode;
        logic        lb;
        logic [15:0] tx;
        logic [15:0] slv;
        logic [15:0] exp_rx;
    } vec_t;

    vec_t vecs [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_mode
        localparam int unsigned P_CPOL = (m >> 1) & 1;
        localparam int unsigned P_CPHA = m & 1;
        logic        sl_miso;
        int          sl_idx;
        logic [15:0] sl_rx_r;
        logic        lead;

        spi_master_ctrl #(
            .CLK_FREQ     (50),
            .SPI_CLK_FREQ (5000),
            .CPOL         (P_CPOL),
            .CPHA         (P_CPHA),
            .DATA_WIDTH   (16),
            .CS_SETUP     (2),
            .CS_HOLD      (2)
        ) u_dut (
            .Clk_I     (clk),
            .RstN_I    (rst_n),
            .TxValid_I (tx_valid[m]),
            .TxData_I  (tx_data[m]),
            .TxReady_O (tx_ready[m]),
            .RxData_O  (rx_data[m]),
            .RxValid_O (rx_valid[m]),
            .Busy_O    (busy[m]),
            .SCK_O     (sck[m]),
            .MOSI_O    (mosi[m]),
            .MISO_I    (lb[m] ? mosi[m] : sl_miso),
            .CS_N_O    (cs_n[m])
        );

        // Slave: CPHA=0 presents MSB at CS fall, CPHA=1 on the first leading edge.
        always @(negedge cs_n[m]) begin
            sl_idx  = 0;
            sl_rx_r = '0;
            sl_miso = (P_CPHA == 0) ? slave_word[m][15] : 1'b0;
        end

        always @(sck[m]) begin
            if (cs_n[m] == 1'b0) begin
                lead = (sck[m] != 1'(P_CPOL));
                if (lead != 1'(P_CPHA)) begin
                    sl_rx_r = {sl_rx_r[14:0], mosi[m]};
                end else if (P_CPHA == 0) begin
                    sl_idx = sl_idx + 1;
                    if (sl_idx < 16) sl_miso = slave_word[m][15 - sl_idx];
                end else begin
                    if (sl_idx < 16) sl_miso = slave_word[m][15 - sl_idx];
                    sl_idx = sl_idx + 1;
                end
            end
        end

        assign sl_rx[m] = sl_rx_r;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One frame on instance m; returns at the negedge where RxValid_O is seen.
    task automatic run_frame(input int m, input logic [15:0] data,
                             output logic [15:0] rx, output int lat,
                             output int rises, output logic mosi_bad);
        logic prev;
        lat      = 0;
        rises    = 0;
        mosi_bad = 1'b0;
        rx       = '0;
        @(negedge clk);
        tx_valid[m] = 1'b1;
        tx_data[m]  = data;
        prev        = sck[m];
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) tx_valid[m] = 1'b0;
            if (sck[m] && !prev) rises++;
            prev = sck[m];
            if (cs_n[m] && mosi[m]) mosi_bad = 1'b1;
            if (rx_valid[m]) begin
                lat = k;
                rx  = rx_data[m];
                break;
            end
        end
    endtask

    initial begin
        logic [15:0] got, rx1, rx2;
        int          lat, rises, extra;
        logic        bad;
        int          md;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_valid[i]   = 1'b0;
            tx_data[i]    = '0;
            lb[i]         = 1'b0;
            slave_word[i] = 16'h3C5A;
        end

        vecs[0] = '{0, 1'b1, 16'hA5C3, 16'h0000, 16'hA5C3};
        vecs[1] = '{0, 1'b0, 16'h1234, 16'h3C5A, 16'h3C5A};
        vecs[2] = '{1, 1'b0, 16'hA5C3, 16'h3C5A, 16'h3C5A};
        vecs[3] = '{2, 1'b0, 16'hA5C3, 16'h3C5A, 16'h3C5A};
        vecs[4] = '{3, 1'b0, 16'hA5C3, 16'h3C5A, 16'h3C5A};
        vecs[5] = '{3, 1'b0, 16'hFFFF, 16'h0000, 16'h0000};
        vecs[6] = '{1, 1'b0, 16'h0000, 16'hFFFF, 16'hFFFF};
        vecs[7] = '{0, 1'b1, 16'h8001, 16'h0000, 16'h8001};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset cs_n", 32'(cs_n[0]), 32'd1);
        check("reset mosi", 32'(mosi[0]), 32'd0);
        check("reset rx_valid", 32'(rx_valid[0]), 32'd0);
        check("reset busy", 32'(busy[0]), 32'd0);
        check("reset rx_data", 32'(rx_data[0]), 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("reset sck m%0d", i), 32'(sck[i]), 32'((i >> 1) & 1));
        rst_n = 1'b1;
        @(negedge clk);
        check("tx_ready after reset", 32'(tx_ready[0]), 32'd1);

        // Table-driven frames across all modes
        for (int i = 0; i < 8; i++) begin
            md             = vecs[i].mode;
            lb[md]         = vecs[i].lb;
            slave_word[md] = vecs[i].slv;
            run_frame(md, vecs[i].tx, got, lat, rises, bad);
            check($sformatf("row%0d rx_data", i), 32'(got), 32'(vecs[i].exp_rx));
            check($sformatf("row%0d latency", i), 32'(lat), 32'(EXP_LAT));
            check($sformatf("row%0d sck rises", i), 32'(rises), 32'(EXP_RISES));
            check($sformatf("row%0d slave saw mosi", i), 32'(sl_rx[md]), 32'(vecs[i].tx));
            check($sformatf("row%0d sck idle", i), 32'(sck[md]), 32'((md >> 1) & 1));
            check($sformatf("row%0d mosi with cs high", i), 32'(bad), 32'd0);
            @(negedge clk);
            check($sformatf("row%0d rx_valid one cycle", i), 32'(rx_valid[md]), 32'd0);
            check($sformatf("row%0d rx_data held", i), 32'(rx_data[md]), 32'(vecs[i].exp_rx));
            lb[md] = 1'b0;
        end

        // Back-to-back with TxValid_I held high
        lb[0] = 1'b1;
        rx1   = '0;
        rx2   = '0;
        lat   = 0;
        @(negedge clk);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 16'h0001;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) tx_data[0] = 16'h8000;
            if (rx_valid[0]) begin
                rx1 = rx_data[0];
                break;
            end
        end
        check("b2b cs high in gap", 32'(cs_n[0]), 32'd1);
        @(negedge clk);
        tx_valid[0] = 1'b0;
        check("b2b cs low after 1 cycle", 32'(cs_n[0]), 32'd0);
        check("b2b busy second frame", 32'(busy[0]), 32'd1);
        for (int k = 2; k <= 400; k++) begin
            @(negedge clk);
            if (rx_valid[0]) begin
                rx2 = rx_data[0];
                lat = k;
                break;
            end
        end
        check("b2b frame1 rx", 32'(rx1), 32'h0001);
        check("b2b frame2 rx", 32'(rx2), 32'h8000);
        check("b2b frame2 latency", 32'(lat), 32'(EXP_LAT));
        extra = 0;
        repeat (200) begin
            @(negedge clk);
            if (rx_valid[0]) extra++;
        end
        check("b2b no extra frame", 32'(extra), 32'd0);

        // TxValid_I pulses during SHIFT are ignored
        got = '0;
        lat = 0;
        @(negedge clk);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 16'h5A5A;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 30 || k == 60 || k == 100) begin
                tx_valid[0] = 1'b1;
                tx_data[0]  = 16'hFFFF;
            end else begin
                tx_valid[0] = 1'b0;
            end
            if (rx_valid[0]) begin
                got = rx_data[0];
                lat = k;
                break;
            end
        end
        tx_valid[0] = 1'b0;
        check("pulse rx", 32'(got), 32'h5A5A);
        check("pulse latency", 32'(lat), 32'(EXP_LAT));
        extra = 0;
        repeat (200) begin
            @(negedge clk);
            if (rx_valid[0]) extra++;
        end
        check("pulse frame count", 32'(extra), 32'd0);

        // Reset asserted during bit 7 of a frame
        @(negedge clk);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 16'hFFFF;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (75) @(negedge clk);
        check("midreset busy before", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset cs_n", 32'(cs_n[0]), 32'd1);
        check("midreset sck", 32'(sck[0]), 32'd0);
        check("midreset mosi", 32'(mosi[0]), 32'd0);
        check("midreset busy", 32'(busy[0]), 32'd0);
        check("midreset rx_valid", 32'(rx_valid[0]), 32'd0);
        rst_n = 1'b1;
        extra = 0;
        repeat (200) begin
            @(negedge clk);
            if (rx_valid[0]) extra++;
        end
        check("midreset no rx_valid", 32'(extra), 32'd0);
        run_frame(0, 16'h1234, got, lat, rises, bad);
        check("post reset rx", 32'(got), 32'h1234);
        check("post reset latency", 32'(lat), 32'(EXP_LAT));
        check("post reset sck rises", 32'(rises), 32'(EXP_RISES));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50: system clock in MHz.
REQ-002 SHALL have parameter SPI_CLK_FREQ, default 1000: SCK frequency in kHz.
REQ-003 SHALL have parameter CPOL, default 0: SCK idle level; 0 means idle low.
REQ-004 SHALL have parameter CPHA, default 0: 0 means sample on first SCK edge, 1 means sample on second.
REQ-005 SHALL have parameter DATA_WIDTH, default 16: bits per frame, range 2..32.
REQ-006 SHALL have parameter CS_SETUP, default 2: Clk_I cycles from CS_N_O low to SCK enable, at least 1.
REQ-007 SHALL have parameter CS_HOLD, default 2: Clk_I cycles from last SCK edge to CS_N_O high, at least 1.
REQ-008 SHALL have ports:
- Clk_I  in  1  system clock.
- RstN_I  in  1  reset. One clock, Clk_I; reset is synchronous and active-low.
- TxValid_I  in  1  frame request.
- TxData_I  in  DATA_WIDTH  frame to send, MSB first.
- TxReady_O  out  1  controller can accept a frame.
- RxData_O  out  DATA_WIDTH  last received frame.
- RxValid_O  out  1  one-cycle strobe: RxData_O updated.
- Busy_O  out  1  transfer in progress.
- SCK_O  out  1  SPI clock.
- MOSI_O  out  1  serial data out.
- MISO_I  in  1  serial data in.
- CS_N_O  out  1  chip select, active low.

Function
REQ-009 SHALL implement FSM IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
REQ-010 TxReady_O SHALL equal (state==IDLE); Busy_O SHALL equal (state!=IDLE).
REQ-011 A handshake (TxValid_I & TxReady_O) in cycle T SHALL load the shift register with TxData_I, drive MOSI_O = TxData_I[DATA_WIDTH-1], and set CS_N_O low from T+1.
REQ-012 TxValid_I outside IDLE SHALL be ignored; TxData_I SHALL be sampled only at the handshake.
REQ-013 SETUP SHALL last exactly CS_SETUP cycles, then assert the SCK generator enable and enter SHIFT.
REQ-014 In SHIFT, SCK_O SHALL toggle every CLK_DIV/2 cycles, where CLK_DIV = CLK_FREQ*1000/SPI_CLK_FREQ, an even integer of at least 4.
REQ-015 CPHA=0: MISO_I SHALL be sampled on each first edge, and MOSI_O SHALL shift to the next bit on each second edge except the last.
REQ-016 CPHA=1: MOSI_O SHALL shift on each first edge except the first edge of bit 0, which presents the already-loaded MSB; MISO_I SHALL be sampled on each second edge.
REQ-017 An edge counter SHALL count SCK edges 0..2*DATA_WIDTH-1.
REQ-018 After edge 2*DATA_WIDTH-1, SCK SHALL be disabled, SCK_O SHALL be at CPOL, and the FSM SHALL enter HOLD.
REQ-019 HOLD SHALL last CS_HOLD cycles, then CS_N_O goes high, RxData_O loads the received word (first sampled bit in the MSB), RxValid_O pulses for 1 cycle, and the FSM returns to IDLE.
REQ-020 RxData_O SHALL hold its value until the next frame completes.
REQ-021 The minimum CS_N_O high time between back-to-back frames SHALL be 1 cycle: handshake possible in the first IDLE cycle.
REQ-022 A frame SHALL span exactly 1 + CS_SETUP + DATA_WIDTH*CLK_DIV + CS_HOLD cycles from handshake to RxValid_O.
REQ-023 MOSI_O SHALL be 0 while CS_N_O is high.

Reset
REQ-024 While RstN_I is low at a Clk_I edge, the block SHALL set: state IDLE, CS_N_O 1, SCK_O CPOL, MOSI_O 0, RxData_O 0, RxValid_O 0, Busy_O 0, TxReady_O 1 (from the first cycle after release), counters 0, SCK generator disabled.
REQ-025 Reset mid-frame SHALL abort without a RxValid_O pulse; CS_N_O SHALL rise at the same edge.

Structure
REQ-026 Edge-role mapping and the state encoding SHALL live in shared package spi_pkg, along with the CLK_DIV derivation.
REQ-027 SCK generation SHALL use one sub-module, spi_clock, with an active-high reset driven by ~RstN_I and enable from this FSM, returning first/second edge strobes.
REQ-028 Behaviour for parameters outside their stated ranges is undefined.

Verification (CLK_FREQ=50, SPI_CLK_FREQ=5000, CLK_DIV=10, DATA_WIDTH=16)
REQ-029 Loopback test: MISO_I=MOSI_O, send 0xA5C3 with CPOL=0/CPHA=0 -> RxData_O=0xA5C3, RxValid_O at cycle 1+2+160+2=165, 16 rising edges on SCK_O.
REQ-030 All four CPOL/CPHA modes, slave model returns 0x3C5A -> RxData_O=0x3C5A each mode; SCK_O idles at CPOL and MOSI_O is stable at every sample edge.
REQ-031 TxValid_I held high with 0x0001 then 0x8000 -> two frames, CS_N_O high exactly 1 cycle between them, second TxData_I ignored until TxReady_O.
REQ-032 RstN_I low for 1 cycle at bit 7 of a frame -> CS_N_O high, SCK_O=CPOL, no RxValid_O, next frame 0x1234 loops back correctly.
REQ-033 TxValid_I pulses during SHIFT -> no effect; the frame count equals the handshake count.
